// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared I/O request encodings and controller state type
package io_pkg;

  localparam logic [1:0] IO_NONE = 2'b00;
  localparam logic [1:0] IO_OUT  = 2'b01;
  localparam logic [1:0] IO_IN   = 2'b10;
  localparam logic [1:0] IO_RSVD = 2'b11;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } io_state_t;

endpackage

// File: rtl/button_debouncer.sv
// rtl/button_debouncer.sv - two-flop synchroniser plus stability-count debouncer
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    cnt_d   = '0;
    // Count only while the synchronised input disagrees; any agreement restarts the window.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;

endmodule

// File: rtl/io_request_controller.sv
// rtl/io_request_controller.sv - stalls on input requests until a debounced button press,
// latches output-request data into the display register
module io_request_controller
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_W            = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      io_ctrl,
  input  logic [31:0]     wdata,
  input  logic            botao_in,
  input  logic [SW_W-1:0] switches,
  output logic            stall,
  output logic [31:0]     rdata,
  output logic            rdata_valid,
  output logic [31:0]     display_value,
  output logic            display_valid
);

  io_state_t   state_q, state_d;
  logic [31:0] rdata_q, rdata_d;
  logic        rdata_valid_q, rdata_valid_d;
  logic [31:0] display_value_q, display_value_d;
  logic        display_valid_q, display_valid_d;
  logic        btn_db;
  logic        is_in;
  logic        is_abort;

  button_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk  (clk),
    .reset(reset),
    .raw  (botao_in),
    .level(btn_db)
  );

  assign is_in    = (io_ctrl == IO_IN);
  // An output request while waiting for the press is serviced without dropping the pending input.
  assign is_abort = (io_ctrl == IO_NONE) || (io_ctrl == IO_RSVD);

  always_comb begin
    state_d         = state_q;
    rdata_d         = rdata_q;
    rdata_valid_d   = 1'b0;
    display_value_d = display_value_q;
    display_valid_d = display_valid_q;

    case (state_q)
      IDLE: begin
        if (is_in) begin
          state_d = btn_db ? WAIT_RELEASE : WAIT_PRESS;
        end
      end
      WAIT_PRESS: begin
        if (is_abort) begin
          state_d = IDLE;
        end else if (btn_db) begin
          state_d              = CAPTURE;
          rdata_d              = '0;
          rdata_d[SW_W-1:0]    = switches;
          rdata_valid_d        = 1'b1;
        end
      end
      CAPTURE: begin
        state_d = WAIT_RELEASE;
      end
      WAIT_RELEASE: begin
        if (!btn_db) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (io_ctrl == IO_OUT) begin
      display_value_d = wdata;
      display_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      rdata_q         <= '0;
      rdata_valid_q   <= 1'b0;
      display_value_q <= '0;
      display_valid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      rdata_q         <= rdata_d;
      rdata_valid_q   <= rdata_valid_d;
      display_value_q <= display_value_d;
      display_valid_q <= display_valid_d;
    end
  end

  assign stall         = is_in && (state_q != CAPTURE);
  assign rdata         = rdata_q;
  assign rdata_valid   = rdata_valid_q;
  assign display_value = display_value_q;
  assign display_valid = display_valid_q;

endmodule
